// File: rtl/riscv_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_arbiter_if
// Purpose  : Bundle of the writeback, long-latency-unit and register-file
//            signals that the writeback arbiter sits between.
// Ports    : pipe_*  writeback-stage write request (in-order path)
//            lu_*    long-latency unit result handshake (valid/ready)
//            rf_*    register-file write port (registered by the arbiter)
//            stall_o pipeline freeze request, pend_o queued-result flag
// Modports : slave  - the arbiter
//            master - the surrounding pipeline / LU / register file
// Revision : 1.0  initial release
// ============================================================================
interface riscv_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_we_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_data_i;
  logic            lu_valid_i;
  logic            lu_ready_o;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            stall_o;
  logic            pend_o;

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i,
    input  lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    output stall_o, pend_o
  );

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i,
    output lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    input  stall_o, pend_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_wb_arbiter
// Purpose  : Shares the single register-file write port between the in-order
//            writeback path and a long-latency unit (mul/div). Pipeline writes
//            always win; LU results wait in a DEPTH-entry FIFO and drain into
//            free slots. A head-age counter raises stall_o when the FIFO head
//            has been starved for STALL_LIMIT cycles. All RF outputs are
//            registered (one cycle added to every write).
// Ports    : clk    rising-edge clock
//            rst_n  synchronous active-low reset
//            bus    riscv_wb_arbiter_if.slave:
//                   pipe_we_i/pipe_rd_i/pipe_data_i  writeback request
//                   lu_valid_i/lu_ready_o/lu_rd_i/lu_data_i  LU handshake
//                   rf_we_o/rf_waddr_o/rf_wdata_o    RF write (registered)
//                   stall_o  freeze request, pend_o  valid entry queued
// Options  : RISCV_WB_BYPASS_EN - when defined, an LU result arriving while
//            the FIFO is empty and the pipeline is not writing goes straight
//            to the RF without being enqueued.
// Revision : 1.0  initial release
// ============================================================================
module riscv_wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  riscv_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  // FIFO storage; unoccupied slots always have their valid bit clear, so the
  // valid vector alone tells whether any live result is queued.
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [4:0]      fifo_rd_d   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_data_d [DEPTH];
  logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  state_t           state_q, state_d;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            stall_q, stall_d;
  logic            pend_q, pend_d;

  logic pipe_own;      // pipeline owns the port slot this cycle
  logic lu_ready;
  logic lu_fire;
  logic head_vld;
  logic head_blocked;  // valid head lost the slot to the pipeline
  logic head_kill;     // valid head invalidated by a younger pipeline write
  logic pop;
  logic push;
  logic bypass;
  logic any_vld_d;

  always_comb begin
    pipe_own     = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
    lu_ready     = (count_q != CNT_W'(DEPTH));
    lu_fire      = bus.lu_valid_i && lu_ready;
    head_vld     = fifo_vld_q[rptr_q];
    head_blocked = head_vld && pipe_own;
    head_kill    = head_blocked && (fifo_rd_q[rptr_q] == bus.pipe_rd_i);
    // Invalid heads pop without the port, so they may retire alongside a
    // pipeline write; valid heads pop only when they actually get the slot.
    pop          = (count_q != '0) && (!head_vld || !pipe_own);
`ifdef RISCV_WB_BYPASS_EN
    bypass       = lu_fire && (bus.lu_rd_i != 5'd0) && (count_q == '0) && !pipe_own;
`else
    bypass       = 1'b0;
`endif
    // rd==0 results are acknowledged but never stored.
    push         = lu_fire && (bus.lu_rd_i != 5'd0) && !bypass;
  end

  // FIFO next state
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;

    // WAW: the pipeline write is younger than anything queued for the same rd.
    if (pipe_own) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_rd_q[i] == bus.pipe_rd_i) begin
          fifo_vld_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      fifo_vld_d[rptr_q] = 1'b0;
    end

    // A result arriving together with a pipeline write to the same rd is
    // treated as the older one, so it enters the FIFO already dead.
    if (push) begin
      fifo_rd_d[wptr_q]   = bus.lu_rd_i;
      fifo_data_d[wptr_q] = bus.lu_data_i;
      fifo_vld_d[wptr_q]  = !(pipe_own && (bus.lu_rd_i == bus.pipe_rd_i));
    end

    wptr_d    = wptr_q + PTR_W'(push);
    rptr_d    = rptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    any_vld_d = |fifo_vld_d;
  end

  // Head age and state machine
  always_comb begin
    age_d = age_q;
    if (pop || head_kill || (count_d == '0)) begin
      age_d = '0;
    end else if (head_blocked && (age_q != AGE_W'(STALL_LIMIT))) begin
      age_d = age_q + AGE_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_vld_d) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!any_vld_d) begin
          state_d = ST_IDLE;
        end else if (head_blocked && !head_kill && (age_d == AGE_W'(STALL_LIMIT))) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // Leave once the starved head is gone, either written or killed.
        if ((pop && head_vld) || head_kill) begin
          state_d = any_vld_d ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_d = (state_d == ST_FORCE);
    pend_d  = (state_d != ST_IDLE);
  end

  // Port slot selection
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = '0;
    if (pipe_own) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.pipe_rd_i;
      rf_wdata_d = bus.pipe_data_i;
    end else if (head_vld) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[rptr_q];
      rf_wdata_d = fifo_data_q[rptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.lu_rd_i;
      rf_wdata_d = bus.lu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_vld_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      age_q      <= '0;
      state_q    <= ST_IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      fifo_vld_q <= fifo_vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      pend_q     <= pend_d;
    end
  end

  // Payload storage needs no reset: slots are only read while valid.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.lu_ready_o = lu_ready;
  assign bus.rf_we_o    = rf_we_q;
  assign bus.rf_waddr_o = rf_waddr_q;
  assign bus.rf_wdata_o = rf_wdata_q;
  assign bus.stall_o    = stall_q;
  assign bus.pend_o     = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_wb_arbiter
// Purpose  : Self-checking bench for riscv_wb_arbiter. Directed vector table
//            and hand-written conflict/full sequences, then random traffic
//            compared against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_wb_arbiter;
  localparam int XLEN        = 32;
  localparam int DEPTH       = 4;
  localparam int STALL_LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  riscv_wb_arbiter #(
    .XLEN(XLEN), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        chk_ready;
    logic        ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        pend;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        v;
  } ent_t;

  ent_t        mq[$];
  int          m_age   = 0;
  logic        m_force = 1'b0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;

  function automatic logic m_pend();
    foreach (mq[i]) if (mq[i].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic own, fire, hv, blocked, killed, popped, byp;
    if (!rst_n) begin
      mq.delete();
      m_age = 0; m_force = 1'b0;
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
      return;
    end
    own     = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
    fire    = bus.lu_valid_i && (mq.size() != DEPTH);
    hv      = (mq.size() > 0) ? mq[0].v : 1'b0;
    byp     = 1'b0;
`ifdef RISCV_WB_BYPASS_EN
    byp     = fire && (bus.lu_rd_i != 5'd0) && (mq.size() == 0) && !own;
`endif
    m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    if (own) begin
      m_we = 1'b1; m_waddr = bus.pipe_rd_i; m_wdata = bus.pipe_data_i;
    end else if (hv) begin
      m_we = 1'b1; m_waddr = mq[0].rd; m_wdata = mq[0].data;
    end else if (byp) begin
      m_we = 1'b1; m_waddr = bus.lu_rd_i; m_wdata = bus.lu_data_i;
    end
    blocked = hv && own;
    killed  = blocked && (mq[0].rd == bus.pipe_rd_i);
    popped  = (mq.size() > 0) && !(hv && own);
    if (own) foreach (mq[i]) if (mq[i].rd == bus.pipe_rd_i) mq[i].v = 1'b0;
    if (popped) void'(mq.pop_front());
    if (fire && (bus.lu_rd_i != 5'd0) && !byp)
      mq.push_back('{bus.lu_rd_i, bus.lu_data_i,
                     !(own && (bus.lu_rd_i == bus.pipe_rd_i))});
    if (popped || killed || (mq.size() == 0)) m_age = 0;
    else if (blocked && (m_age < STALL_LIMIT)) m_age++;
    if (m_force) begin
      if ((popped && hv) || killed) m_force = 1'b0;
    end else if (blocked && !killed && (m_age == STALL_LIMIT)) begin
      m_force = 1'b1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t V(input logic r, input logic pwe, input logic [4:0] prd,
                             input logic [31:0] pdata, input logic lv, input logic [4:0] lrd,
                             input logic [31:0] ldata, input logic cr, input logic rdy,
                             input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic st, input logic pn);
    vec_t v;
    v.rst_n = r; v.pwe = pwe; v.prd = prd; v.pdata = pdata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.chk_ready = cr; v.ready = rdy;
    v.we = we; v.waddr = wa; v.wdata = wd; v.stall = st; v.pend = pn;
    return v;
  endfunction

  // One clock: drive inputs, check ready before the edge, check registered
  // outputs 1ns after it, against either the vector or the model.
  task automatic apply(input vec_t v, input string tag, input logic use_model);
    logic exp_ready;
    rst_n           = v.rst_n;
    bus.pipe_we_i   = v.pwe;
    bus.pipe_rd_i   = v.prd;
    bus.pipe_data_i = v.pdata;
    bus.lu_valid_i  = v.lv;
    bus.lu_rd_i     = v.lrd;
    bus.lu_data_i   = v.ldata;
    #1;
    exp_ready = (mq.size() != DEPTH);
    if (use_model) chk({tag, ".ready"}, 32'(bus.lu_ready_o), 32'(exp_ready));
    else if (v.chk_ready) chk({tag, ".ready"}, 32'(bus.lu_ready_o), 32'(v.ready));
    @(posedge clk);
    model_step();
    #1;
    if (use_model) begin
      chk({tag, ".we"},    32'(bus.rf_we_o),    32'(m_we));
      chk({tag, ".waddr"}, 32'(bus.rf_waddr_o), 32'(m_waddr));
      chk({tag, ".wdata"}, bus.rf_wdata_o,      m_wdata);
      chk({tag, ".stall"}, 32'(bus.stall_o),    32'(m_force));
      chk({tag, ".pend"},  32'(bus.pend_o),     32'(m_pend()));
    end else begin
      chk({tag, ".we"},    32'(bus.rf_we_o),    32'(v.we));
      chk({tag, ".waddr"}, 32'(bus.rf_waddr_o), 32'(v.waddr));
      chk({tag, ".wdata"}, bus.rf_wdata_o,      v.wdata);
      chk({tag, ".stall"}, 32'(bus.stall_o),    32'(v.stall));
      chk({tag, ".pend"},  32'(bus.pend_o),     32'(v.pend));
    end
  endtask

  initial begin
    vec_t tab[$];
    vec_t v;
    int   mode;
    int   pct;

    // Directed table: reset, idle drain, WAW kill, rd=0 handling.
    //         rst pwe prd pdata    lv lrd ldata    cr rdy we wa wdata    st pn
    tab.push_back(V(0, 0, 0, 0,        1, 4, 32'h55,   0, 0,  0, 0, 0,        0, 0));
    tab.push_back(V(0, 0, 0, 0,        1, 4, 32'h55,   1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
`ifdef RISCV_WB_BYPASS_EN
    tab.push_back(V(1, 0, 0, 0,        1, 5, 32'h1234, 1, 1,  1, 5, 32'h1234, 0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
`else
    tab.push_back(V(1, 0, 0, 0,        1, 5, 32'h1234, 1, 1,  0, 0, 0,        0, 1));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  1, 5, 32'h1234, 0, 0));
`endif
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 1, 3, 32'h33,   1, 9, 32'h77,   1, 1,  1, 3, 32'h33,   0, 1));
    tab.push_back(V(1, 1, 9, 32'hAA,   0, 0, 0,        1, 1,  1, 9, 32'hAA,   0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 1, 2, 32'h22,   1, 0, 32'h99,   1, 1,  1, 2, 32'h22,   0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));
    tab.push_back(V(1, 1, 1, 32'h11,   1, 6, 32'h66,   1, 1,  1, 1, 32'h11,   0, 1));
    tab.push_back(V(1, 1, 0, 32'hDEAD, 0, 0, 0,        1, 1,  1, 6, 32'h66,   0, 0));
    tab.push_back(V(1, 0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 0,        0, 0));

    foreach (tab[i]) apply(tab[i], $sformatf("tab%0d", i), 1'b0);

    // Starvation: pipe writes rd=3 every cycle; LU rd=7 waits, stall after
    // eight blocked cycles, drains on the first idle cycle.
    for (int c = 0; c < 12; c++) begin
      apply(V(1, 1, 3, 32'h300 + 32'(c), (c == 0), 7, 32'h700, 1, 1,
              1, 3, 32'h300 + 32'(c), (c >= 8), 1), $sformatf("starve%0d", c), 1'b0);
    end
    apply(V(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h700, 0, 0), "starve_drain", 1'b0);
    apply(V(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,       0, 0), "starve_after", 1'b0);

    // Full FIFO: back-pressure, held 5th result, push+pop at count 3.
    apply(V(1, 1, 3, 32'h30, 1, 10, 32'hA00, 1, 1, 1, 3,  32'h30,  0, 1), "full0", 1'b0);
    apply(V(1, 1, 3, 32'h30, 1, 11, 32'hB00, 1, 1, 1, 3,  32'h30,  0, 1), "full1", 1'b0);
    apply(V(1, 1, 3, 32'h30, 1, 12, 32'hC00, 1, 1, 1, 3,  32'h30,  0, 1), "full2", 1'b0);
    apply(V(1, 1, 3, 32'h30, 1, 13, 32'hD00, 1, 1, 1, 3,  32'h30,  0, 1), "full3", 1'b0);
    apply(V(1, 1, 3, 32'h30, 1, 14, 32'hE00, 1, 0, 1, 3,  32'h30,  0, 1), "full4", 1'b0);
    apply(V(1, 0, 0, 0,      1, 14, 32'hE00, 1, 0, 1, 10, 32'hA00, 0, 1), "full5", 1'b0);
    apply(V(1, 1, 3, 32'h30, 1, 14, 32'hE00, 1, 1, 1, 3,  32'h30,  0, 1), "full6", 1'b0);
    apply(V(1, 0, 0, 0,      1, 15, 32'hF00, 1, 0, 1, 11, 32'hB00, 0, 1), "full7", 1'b0);
    apply(V(1, 0, 0, 0,      1, 15, 32'hF00, 1, 1, 1, 12, 32'hC00, 0, 1), "full8", 1'b0);
    apply(V(1, 1, 3, 32'h30, 0, 0,  0,       1, 1, 1, 3,  32'h30,  0, 1), "full9", 1'b0);
    apply(V(1, 0, 0, 0,      0, 0,  0,       1, 1, 1, 13, 32'hD00, 0, 1), "full10", 1'b0);
    apply(V(1, 0, 0, 0,      0, 0,  0,       1, 1, 1, 14, 32'hE00, 0, 1), "full11", 1'b0);
    apply(V(1, 0, 0, 0,      0, 0,  0,       1, 1, 1, 15, 32'hF00, 0, 0), "full12", 1'b0);
    apply(V(1, 0, 0, 0,      0, 0,  0,       1, 1, 0, 0,  0,       0, 0), "full13", 1'b0);

    // Random traffic against the reference model.
    v = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v, "rand_rst", 1'b1);
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 40) == 0) mode = int'($urandom_range(0, 2));
      pct     = (mode == 0) ? 30 : ((mode == 1) ? 100 : 85);
      v.rst_n = ($urandom_range(0, 299) != 0);
      v.pwe   = (int'($urandom_range(0, 99)) < pct);
      v.prd   = 5'($urandom_range(0, 15));
      v.pdata = $urandom;
      v.lv    = 1'($urandom_range(0, 1));
      v.lrd   = 5'($urandom_range(0, 7));
      v.ldata = $urandom;
      apply(v, $sformatf("rand%0d", n), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
